// File: rtl/divider_multi_if.sv
// Configuration request/response bundle for divider_multi.
interface divider_multi_if #(
  parameter int CH_NUM = 4,
  parameter int DIV_W  = 8
);
  localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  logic             cfg_valid;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_mode;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (output cfg_valid, cfg_ch, cfg_div, cfg_mode, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_mode, output cfg_ready, cfg_err);
endinterface

// File: rtl/divider_multi.sv
// Multi-channel programmable clock-enable divider with registered pulse and square outputs.
// Config lands in a per-channel shadow, applied at the next wrap; cfg_ready low while a shadow is pending.
module divider_multi #(
  parameter int CH_NUM  = 4,
  parameter int DIV_W   = 8,
  parameter int DIV_DEF = 6,
  localparam int CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [CH_NUM-1:0] ch_en,
  input  logic              sync_rst,
  divider_multi_if.slave    cfg,
  output logic [CH_NUM-1:0] clk_flag,
  output logic [CH_NUM-1:0] clk_out
);
  localparam int          CH_SPAN = 1 << CH_W;
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DIV_DEF);

  logic [DIV_W-1:0]   cnt_q  [CH_NUM];
  logic [DIV_W-1:0]   div_q  [CH_NUM];
  logic [DIV_W-1:0]   sdiv_q [CH_NUM];
  logic [DIV_W-1:0]   cnt_d  [CH_NUM];
  logic [DIV_W-1:0]   div_d  [CH_NUM];
  logic [CH_NUM-1:0]  mode_q, smode_q, pend_q;
  logic [CH_NUM-1:0]  mode_d, pend_d, flag_d, out_d;
  logic [CH_NUM-1:0]  acc_ch, wrap, boundary, apply_sh, run;
  logic [CH_SPAN-1:0] pend_pad, ch_map;
  logic               ch_ok, div_ok, ready, accept, cfg_err_q;

  // Padded views let a select value beyond CH_NUM-1 index safely.
  always_comb begin
    pend_pad = '0;
    pend_pad[CH_NUM-1:0] = pend_q;
    ch_map = '0;
    ch_map[CH_NUM-1:0] = '1;
  end

  assign ch_ok  = ch_map[cfg.cfg_ch];
  assign div_ok = (cfg.cfg_div >= DIV_W'(2));
  assign ready  = ch_ok && !pend_pad[cfg.cfg_ch];
  assign accept = cfg.cfg_valid && ready && div_ok;

  assign cfg.cfg_ready = ready;
  assign cfg.cfg_err   = cfg_err_q;

  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      acc_ch[i]   = accept && (cfg.cfg_ch == CH_W'(i));
      wrap[i]     = ch_en[i] && (cnt_q[i] == div_q[i] - ONE);
      boundary[i] = sync_rst || !ch_en[i] || wrap[i];
      apply_sh[i] = pend_q[i] && boundary[i];
      run[i]      = ch_en[i] && !sync_rst;
      cnt_d[i]    = boundary[i] ? '0 : cnt_q[i] + ONE;
      div_d[i]    = div_q[i];
      mode_d[i]   = mode_q[i];
      // A config accepted under sync_rst bypasses the shadow entirely.
      if (sync_rst && acc_ch[i]) begin
        div_d[i]  = cfg.cfg_div;
        mode_d[i] = cfg.cfg_mode;
      end else if (apply_sh[i]) begin
        div_d[i]  = sdiv_q[i];
        mode_d[i] = smode_q[i];
      end
      pend_d[i] = (pend_q[i] && !apply_sh[i]) || (acc_ch[i] && !sync_rst);
      flag_d[i] = run[i] && (cnt_d[i] == div_d[i] - ONE);
      out_d[i]  = run[i] && mode_d[i] && (cnt_d[i] >= (div_d[i] >> 1));
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < CH_NUM; i++) begin
        cnt_q[i]  <= '0;
        div_q[i]  <= DEF_DIV;
        sdiv_q[i] <= DEF_DIV;
      end
      mode_q    <= '0;
      smode_q   <= '0;
      pend_q    <= '0;
      clk_flag  <= '0;
      clk_out   <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        cnt_q[i] <= cnt_d[i];
        div_q[i] <= div_d[i];
        if (acc_ch[i]) begin
          sdiv_q[i]  <= cfg.cfg_div;
          smode_q[i] <= cfg.cfg_mode;
        end
      end
      mode_q    <= mode_d;
      pend_q    <= pend_d;
      clk_flag  <= flag_d;
      clk_out   <= out_d;
      cfg_err_q <= cfg.cfg_valid && !(ch_ok && div_ok);
    end
  end
endmodule
